// File: rtl/instruction_mem_loader.sv
// Byte-stream to instruction-memory loader: assembles little-endian words from a
// valid/ready byte stream and writes them to consecutive addresses from a base.
module instruction_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddress,
  input  logic [ADDR_WIDTH:0]   wordCount,
  input  logic [7:0]            byteData,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BCNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH+1:0] MEM_DEPTH = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH+1:0] end_addr;

  // One past the last address the requested load would touch.
  assign end_addr = {2'b00, baseAddress} + {1'b0, wordCount};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    waddr_d  = waddr_q;
    remain_d = remain_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (end_addr > MEM_DEPTH) begin
            err_d = 1'b1;
          end else if (wordCount == '0) begin
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            addr_d   = baseAddress;
            remain_d = wordCount;
            bcnt_d   = '0;
            err_d    = 1'b0;
            state_d  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (byteValid) begin
          asm_d[{bcnt_q, 3'b000} +: 8] = byteData;
          if (bcnt_q == LAST_BYTE) begin
            // Capture the finished word so the write port holds it after WRITE.
            bcnt_d   = '0;
            remain_d = remain_q - (ADDR_WIDTH+1)'(1);
            waddr_d  = addr_q;
            wdata_d  = asm_d;
            state_d  = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (remain_q != '0) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      waddr_q  <= '0;
      remain_q <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      waddr_q  <= waddr_d;
      remain_q <= remain_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign byteReady       = (state_q == S_LOAD);
  assign memWriteEnable  = (state_q == S_WRITE);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign error           = err_q;
  assign memWriteAddress = waddr_q;
  assign memWriteData    = wdata_q;

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Bench for instruction_mem_loader: expected writes are derived from the byte
// stream and load parameters, then matched against every observed write strobe.
module tb_instruction_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  baseAddress;
  logic [10:0] wordCount;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        byteReady;
  logic        memWriteEnable;
  logic [9:0]  memWriteAddress;
  logic [63:0] memWriteData;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  instruction_mem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddress(baseAddress),
    .wordCount(wordCount), .byteData(byteData), .byteValid(byteValid),
    .byteReady(byteReady), .memWriteEnable(memWriteEnable),
    .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
    .busy(busy), .done(done), .error(error)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  stim[$];
  logic [9:0]  q_addr[$];
  logic [63:0] q_data[$];
  logic [9:0]  hold_addr = '0;
  logic [63:0] hold_data = '0;
  int          cyc = 0, wr_count = 0, wr_cyc_last = 0, wr_cyc_prev = 0, done_cyc = 0;
  bit          armed = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word_of(input int w);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r = r | (64'(stim[8*w+b]) << (8*b));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // Per-cycle comparison against the expected-write scoreboard and state rules.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      hold_addr = '0;
      hold_data = '0;
    end else if (armed) begin
      if (memWriteEnable) begin
        wr_count++;
        wr_cyc_prev = wr_cyc_last;
        wr_cyc_last = cyc;
        if (q_addr.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("wr_addr", memWriteAddress, q_addr.pop_front());
          check("wr_data", memWriteData, q_data.pop_front());
        end
        hold_addr = memWriteAddress;
        hold_data = memWriteData;
      end else begin
        check("hold_addr", memWriteAddress, hold_addr);
        check("hold_data", memWriteData, hold_data);
      end
      if (done) done_cyc = cyc;
      if (busy) check("one_activity", 32'(byteReady) + 32'(memWriteEnable) + 32'(done), 1);
      else      check("idle_quiet", {byteReady, memWriteEnable, done}, 3'b000);
    end
  end

  task automatic run_load(input int base, input int cnt, input int mode, input bit intrude);
    int idx, guard, w0;
    bit v, ph;
    bit in_range;
    in_range = (base + cnt) <= 1024;
    w0 = wr_count;
    if (in_range)
      for (int w = 0; w < cnt; w++) begin
        q_addr.push_back(10'(base + w));
        q_data.push_back(word_of(w));
      end
    start = 1'b1; baseAddress = 10'(base); wordCount = 11'(cnt);
    byteValid = 1'b1; byteData = 8'hA5;
    tick();
    start = 1'b0; byteValid = 1'b0;
    if (!in_range) begin
      check("range_err", error, 1);
      check("range_busy", busy, 0);
      tick(); tick();
      check("range_nowr", wr_count, w0);
      check("range_sticky", error, 1);
      return;
    end
    check("start_err_clr", error, 0);
    if (cnt == 0) begin
      check("zero_done", done, 1);
      tick();
      check("zero_done_end", done, 0);
      check("zero_idle", busy, 0);
      check("zero_nowr", wr_count, w0);
      return;
    end
    idx = 0; guard = 0; ph = 1'b1;
    while (idx < cnt*8 && guard < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ph; ph = ~ph; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byteValid = v;
      byteData  = v ? stim[idx] : 8'($urandom);
      if (intrude && idx == 3) begin
        start = 1'b1; baseAddress = 10'($urandom); wordCount = 11'($urandom_range(1, 4));
      end else begin
        start = 1'b0;
      end
      if (v && byteReady) idx++;
      tick();
      guard++;
    end
    byteValid = 1'b0; start = 1'b0;
    check("stream_timeout", idx, cnt*8);
    guard = 0;
    while (!done && guard < 20) begin
      tick();
      guard++;
    end
    check("done_seen", done, 1);
    tick();
    check("done_pulse", done, 0);
    check("busy_drop", busy, 0);
    check("write_count", wr_count - w0, cnt);
    check("queue_empty", q_addr.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt, w0;
    reset = 1'b1; start = 1'b0; baseAddress = '0; wordCount = '0;
    byteData = '0; byteValid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    armed = 1'b1;
    check("rst_outs", {byteReady, memWriteEnable, busy, done, error}, 5'b0);
    check("rst_addr", memWriteAddress, 0);
    check("rst_data", memWriteData, 0);

    // Single word, value 1.
    stim.delete();
    stim.push_back(8'h01);
    for (int i = 0; i < 7; i++) stim.push_back(8'h00);
    check("model_w1", word_of(0), 64'h1);
    run_load(0, 1, 0, 0);
    check("t1_addr", hold_addr, 0);
    check("t1_data", hold_data, 64'h1);
    check("t1_done_after_wr", done_cyc - wr_cyc_last, 1);

    // Two words at base 10, full rate then toggled valid.
    for (int pass = 0; pass < 2; pass++) begin
      stim.delete();
      stim.push_back(8'hFE);
      for (int i = 0; i < 7; i++) stim.push_back(8'hFF);
      for (int i = 8; i >= 1; i--) stim.push_back(8'(i));
      check("model_w2a", word_of(0), 64'hFFFFFFFFFFFFFFFE);
      check("model_w2b", word_of(1), 64'h0102030405060708);
      run_load(10, 2, pass, 0);
      check("t2_last_addr", hold_addr, 11);
      check("t2_last_data", hold_data, 64'h0102030405060708);
      if (pass == 0) check("t2_spacing", wr_cyc_last - wr_cyc_prev, 9);
      else           check("t3_spacing", (wr_cyc_last - wr_cyc_prev) > 9, 1);
    end

    // Range error, then the highest legal single-word load.
    run_load(1020, 5, 0, 0);
    fill_rand(8);
    run_load(1023, 1, 0, 0);
    check("t4_addr", hold_addr, 1023);

    // Zero-length load and a start arriving mid-load.
    run_load(5, 0, 0, 0);
    fill_rand(16);
    run_load(200, 2, 0, 1);
    check("t5_addr", hold_addr, 201);

    // Reset after five bytes of a word.
    fill_rand(8);
    w0 = wr_count;
    start = 1'b1; baseAddress = 10'd100; wordCount = 11'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      byteValid = 1'b1; byteData = stim[i];
      tick();
    end
    byteValid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_outs", {byteReady, memWriteEnable, busy, done, error}, 5'b0);
    check("t6_addr", memWriteAddress, 0);
    check("t6_data", memWriteData, 0);
    tick(); tick();
    check("t6_nowr", wr_count, w0);
    fill_rand(8);
    run_load(100, 1, 0, 0);
    check("t6_reload_data", hold_data, word_of(0));

    // Randomised loads, including out-of-range and zero-length requests.
    for (int it = 0; it < 10; it++) begin
      base = $urandom_range(0, 1023);
      cnt  = $urandom_range(0, 3);
      fill_rand(cnt * 8);
      run_load(base, cnt, 2, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
